// File: rtl/idex_if.sv
// ID/EX stage bus: decoded instruction from ID, registered copy toward EX,
// plus the stall/flush controls and hazard feedback that ride alongside it.
interface idex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [7:0]        id_ctrl;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [7:0]        ex_ctrl;
    logic              ex_memread;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  stall_cycles;
    logic              protocol_err;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ctrl,
        input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_ctrl, ex_memread, pc_write, ifid_write, stall_cycles, protocol_err
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_ctrl,
        output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_ctrl, ex_memread, pc_write, ifid_write, stall_cycles, protocol_err
    );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: loads the ID instruction or inserts a bubble on
// stall/flush, drives PC and IF/ID write enables, counts stalls, flags bad stalls.
module idex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic   clk,
    input logic   rst,
    idex_if.slave bus
);
    logic              vld_p1;
    logic [7:0]        ctrl_p1;
    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] rs_data_p1;
    logic [DATA_W-1:0] rt_data_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [REG_W-1:0]  rs_p1;
    logic [REG_W-1:0]  rt_p1;
    logic [REG_W-1:0]  rd_p1;
    logic [CNT_W-1:0]  stall_cnt;
    logic              err_q;
    logic              bubble;
    logic              stall_taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign bubble      = bus.flush | bus.stall | ~bus.id_valid;
    assign stall_taken = bus.stall & ~bus.flush;

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            // Zeroed register numbers stop the hazard detector matching a stale rt.
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            pc_p1      <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else begin
            vld_p1     <= 1'b1;
            ctrl_p1    <= bus.id_ctrl;
            pc_p1      <= bus.id_pc;
            rs_data_p1 <= bus.id_rs_data;
            rt_data_p1 <= bus.id_rt_data;
            imm_p1     <= bus.id_imm;
            rs_p1      <= bus.id_rs;
            rt_p1      <= bus.id_rt;
            rd_p1      <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (stall_taken)
                stall_cnt <= sat_inc(stall_cnt);
            // A legal load-use stall only ever happens with a load sitting in EX.
            if (stall_taken && !ctrl_p1[5])
                err_q <= 1'b1;
        end
    end

    assign bus.ex_valid     = vld_p1;
    assign bus.ex_ctrl      = ctrl_p1;
    assign bus.ex_pc        = pc_p1;
    assign bus.ex_rs_data   = rs_data_p1;
    assign bus.ex_rt_data   = rt_data_p1;
    assign bus.ex_imm       = imm_p1;
    assign bus.ex_rs        = rs_p1;
    assign bus.ex_rt        = rt_p1;
    assign bus.ex_rd        = rd_p1;
    assign bus.ex_memread   = ctrl_p1[5];
    assign bus.pc_write     = ~bus.stall | bus.flush;
    assign bus.ifid_write   = ~bus.stall | bus.flush;
    assign bus.stall_cycles = stall_cnt;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: directed vectors push expected EX state,
// a monitor pops and compares one cycle later.
module tb_idex_stage_reg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam logic [7:0] LW_CTRL  = 8'hE8;
    localparam logic [7:0] ADD_CTRL = 8'h86;

    typedef struct {
        logic          vld;
        logic [7:0]    ctrl;
        logic [DW-1:0] pc;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] imm;
        logic [14:0]   regs;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t q[$];

    idex_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();
    idex_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus. ld=1 means EX must hold exactly the driven fields next
    // cycle, ld=0 means EX must be all zero.
    task automatic step(input bit r, input bit st, input bit fl, input bit v,
                        input logic [7:0] c, input logic [DW-1:0] pc,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] im, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input bit ld, input bit pcw, input int cnt, input bit err);
        exp_t e;
        @(negedge clk);
        rst = r; bus.stall = st; bus.flush = fl; bus.id_valid = v; bus.id_ctrl = c;
        bus.id_pc = pc; bus.id_rs_data = a; bus.id_rt_data = b; bus.id_imm = im;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        e.vld  = ld;
        e.ctrl = ld ? c : 8'h0;
        e.pc   = ld ? pc : '0;
        e.rsd  = ld ? a : '0;
        e.rtd  = ld ? b : '0;
        e.imm  = ld ? im : '0;
        e.regs = ld ? {rs, rt, rd} : 15'h0;
        e.cnt  = CW'(cnt);
        e.err  = err;
        q.push_back(e);
        #1;
        chk("pc_write", 64'(bus.pc_write), 64'(pcw));
        chk("ifid_write", 64'(bus.ifid_write), 64'(pcw));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", 64'(bus.ex_valid), 64'(e.vld));
                chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(e.ctrl));
                chk("ex_memread", 64'(bus.ex_memread), 64'(e.ctrl[5]));
                chk("ex_pc", 64'(bus.ex_pc), 64'(e.pc));
                chk("ex_rs_data", 64'(bus.ex_rs_data), 64'(e.rsd));
                chk("ex_rt_data", 64'(bus.ex_rt_data), 64'(e.rtd));
                chk("ex_imm", 64'(bus.ex_imm), 64'(e.imm));
                chk("ex_regs", 64'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 64'(e.regs));
                chk("stall_cycles", 64'(bus.stall_cycles), 64'(e.cnt));
                chk("protocol_err", 64'(bus.protocol_err), 64'(e.err));
            end
        end
    end

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};
        tests = 0; fails = 0;
        rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_ctrl = '0; bus.id_pc = '0; bus.id_rs_data = '0; bus.id_rt_data = '0;
        bus.id_imm = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;

        // Reset with random ID contents
        for (int i = 0; i < 2; i++)
            step(1, 0, 0, 1, 8'($urandom), $urandom, $urandom, $urandom, $urandom,
                 5'($urandom), 5'($urandom), 5'($urandom), 0, 1, 0, 0);

        // lw $t0,4($sp) then add $t1,$t0,$t2 with a one-cycle load-use stall
        step(0, 0, 0, 1, LW_CTRL, 32'h0000_0404, 32'h7FFF_EFF0, 32'h1111_2222,
             32'h0000_0004, 5'd29, 5'd8, 5'd0, 1, 1, 0, 0);
        step(0, 1, 0, 1, ADD_CTRL, 32'h0000_0408, 32'hDEAD_0000, 32'h0000_BEEF,
             32'h0000_4820, 5'd8, 5'd10, 5'd9, 0, 0, 1, 0);
        step(0, 0, 0, 1, ADD_CTRL, 32'h0000_0408, 32'hAAAA_5555, 32'h0000_BEEF,
             32'h0000_4820, 5'd8, 5'd10, 5'd9, 1, 1, 1, 0);

        // stall and flush together: flush wins, no count, no error
        step(0, 1, 1, 1, LW_CTRL, 32'h0000_040C, 32'h1234_5678, 32'h9ABC_DEF0,
             32'hFFFF_FFF8, 5'd3, 5'd4, 5'd0, 0, 1, 1, 0);

        // id_valid=0 loads a bubble even with non-zero fields
        step(0, 0, 0, 0, 8'hFF, 32'h0000_0410, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31, 0, 1, 1, 0);

        // Stall with no load in EX: sticky protocol error
        step(0, 1, 0, 1, ADD_CTRL, 32'h0000_0414, 32'h1, 32'h2, 32'h3,
             5'd1, 5'd2, 5'd3, 0, 0, 2, 1);
        step(0, 0, 0, 1, ADD_CTRL, 32'h0000_0418, 32'h5, 32'h6, 32'h7,
             5'd5, 5'd6, 5'd7, 1, 1, 2, 1);
        step(0, 0, 0, 1, LW_CTRL, 32'h0000_041C, 32'h8, 32'h9, 32'hA,
             5'd8, 5'd9, 5'd10, 1, 1, 2, 1);

        // Reset clears the error; reset during a stall still zeroes everything
        step(1, 0, 0, 1, LW_CTRL, 32'h0000_0420, 32'hB, 32'hC, 32'hD,
             5'd11, 5'd12, 5'd13, 0, 1, 0, 0);
        step(1, 1, 0, 1, LW_CTRL, 32'h0000_0424, 32'hE, 32'hF, 32'h10,
             5'd14, 5'd15, 5'd16, 0, 0, 0, 0);

        // Five legal load-use stalls against a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, LW_CTRL, 32'h0000_0500 + 32'(k * 8), 32'h100 + 32'(k),
                 32'h200 + 32'(k), 32'h0000_0010, 5'd29, 5'(k + 8), 5'd0, 1, 1,
                 (k == 0) ? 0 : sat_exp[k-1], 0);
            step(0, 1, 0, 1, ADD_CTRL, 32'h0000_0504 + 32'(k * 8), 32'h300, 32'h400,
                 32'h0, 5'(k + 8), 5'd10, 5'd9, 0, 0, sat_exp[k], 0);
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
